// File: rtl/magnitude_comparator_seq_pkg.sv
// magnitude_comparator_seq_pkg: FSM state encoding and index-width helper shared by comparator variants
package magnitude_comparator_seq_pkg;

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    // Index counter width for n digits, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/magnitude_comparator_seq_if.sv
// magnitude_comparator_seq_if: start/operand request and result flags of the serial comparator
interface magnitude_comparator_seq_if #(parameter int WIDTH = 8);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b
    );

endinterface

// File: rtl/magnitude_comparator_seq_digit_compare.sv
// digit_compare: unsigned compare of one digit pair; equality is implied when neither flag is set
module digit_compare #(parameter int DIGIT = 2) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = a_i > b_i;
    assign lt_o = a_i < b_i;

endmodule

// File: rtl/magnitude_comparator_seq.sv
// magnitude_comparator_seq: digit-serial MSB-first magnitude comparator with early exit and signed mode
module magnitude_comparator_seq
    import magnitude_comparator_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    magnitude_comparator_seq_if.slave  bus
);

    localparam int ND = WIDTH / DIGIT;
    localparam int IW = idx_width(ND);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;
    logic [BW-1:0]    base;
    logic             gt;
    logic             lt;
    logic             last;

    assign base = BW'(WIDTH - DIGIT - DIGIT * int'(idx_q));
    assign last = idx_q == IW'(ND - 1);

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .a_i  (a_q[base +: DIGIT]),
        .b_i  (b_q[base +: DIGIT]),
        .gt_o (gt),
        .lt_o (lt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (bus.start) begin
                    // Flipping the sign bits maps two's-complement order onto unsigned order.
                    a_q     <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                    b_q     <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                    idx_q   <= '0;
                    gt_q    <= 1'b0;
                    lt_q    <= 1'b0;
                    eq_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST_SCAN;
                end
            end else if (gt || lt || last) begin
                gt_q    <= gt;
                lt_q    <= lt;
                eq_q    <= !(gt || lt);
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_gt_b = gt_q;
    assign bus.a_lt_b = lt_q;
    assign bus.a_eq_b = eq_q;

endmodule

// File: doc/magnitude_comparator_seq.md
# magnitude_comparator_seq

Parametrised, digit-serial magnitude comparator: latches two WIDTH-bit operands on a start handshake, scans them MSB-first DIGIT bits per clock, and reports mutually exclusive greater/less/equal flags with a one-cycle done pulse. It supports unsigned and two's-complement modes and terminates early on the first differing digit. It is the wide, multi-cycle successor to the combinational 2-bit comparator, for use where wide operands must not create a long compare path on the Spartan-3 fabric.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 2, bits examined per clock; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when the result flags become valid.
- a_gt_b  output  1  A > B for the last completed comparison.
- a_lt_b  output  1  A < B for the last completed comparison.
- a_eq_b  output  1  A = B for the last completed comparison.

## Operation
- NUM_DIGITS = WIDTH/DIGIT. Digit 0 is the most significant digit, bits [WIDTH-1 : WIDTH-DIGIT].
- FSM has two states:
  - IDLE: busy=0. A start accepted here latches a, b and signed_mode, clears all three flags, sets the digit index to 0, and moves to SCAN.
  - SCAN: busy=1. Each cycle compares digit[idx] of A and B as unsigned DIGIT-bit values.
    - If the digits differ, set a_gt_b or a_lt_b, pulse done, and return to IDLE.
    - If they are equal and idx = NUM_DIGITS-1, set a_eq_b, pulse done, and return to IDLE.
    - Otherwise idx increments.
- Signed mode: the MSB of both latched operands is inverted at latch time (offset-binary mapping), so the unsigned digit scan gives the signed ordering.
- Flags:
  - At most one flag is high at any time.
  - All three are 0 while busy and after reset.
  - Exactly one is high from done until the next accepted start.
- start while busy=1 is ignored; there is no queueing.
- start in the same cycle as done is accepted, giving back-to-back operations.
- Changes on a, b or signed_mode after acceptance do not affect the result in progress.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, a_gt_b=0, a_lt_b=0, a_eq_b=0.
  - idx=0; operand registers are don't-care.
- Latency, with start sampled at edge T0 and the first differing digit at index k:
  - busy=1 from T0 to T0+k+1.
  - done=1 and the flag valid in the cycle after edge T0+k+1; busy=0 in that same cycle.
  - Equal operands take NUM_DIGITS cycles; the minimum is 1 cycle (MSB digit differs).
- Throughput: one new comparison may start in the done cycle.
- done is high for exactly one cycle per accepted start.
- Reset asserted mid-SCAN:
  - Aborts the operation at that edge with no done pulse.
  - All outputs return to their reset values.
  - A start in the same cycle as reset is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared include `comparator_defs.vh` holds:
  - state encodings ST_IDLE and ST_SCAN;
  - the NUM_DIGITS / index-width derivation macro, reused by future comparator variants.
- One combinational sub-module, `digit_compare` (parameter DIGIT): takes two digits and outputs gt and lt; eq is implied when neither is set.
- Top level holds:
  - the FSM;
  - idx counter, width clog2(NUM_DIGITS), minimum 1;
  - operand registers, with the digit at idx selected by indexed part-select;
  - the flag registers.
- Expected size: ~150 RTL lines.

## Test plan
All cases use WIDTH=8, DIGIT=2.
- Unsigned early exit: a=8'hC3, b=8'h3C, signed_mode=0, start one cycle → done one cycle after the start edge; a_gt_b=1, others 0.
- Signed: same operands, signed_mode=1 (-61 vs 60) → done after 1 cycle; a_lt_b=1.
- Full scan, equal: a=b=8'h5A → busy for 4 cycles, then done with a_eq_b=1.
- Full scan, last digit differs: a=8'h12, b=8'h13 unsigned → done after 4 cycles with a_lt_b=1.
- Handshake:
  - start held high continuously with varying operands → only starts in IDLE/done cycles are accepted;
  - one done per accepted start;
  - flags unchanged by inputs while busy.
- Reset mid-SCAN:
  - assert reset on the 2nd SCAN cycle of a=b=8'hFF → next cycle all outputs 0 and no done pulse;
  - a following start with a=8'h01, b=8'h80, signed_mode=1 → a_gt_b=1.
